ws_sequencer: RTL and testbench

WS_SEQUENCER -- requirements
Module: ws_sequencer

---
 rtl/ws_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ws_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_sequencer.sv
// Weight-stationary conv sequencer: weight load, execute, psum drain and accumulation, driving a 40-bit core instruction.
// Build option WS_SEQ_OVERLAP_EN: GAP moves straight to the next kij instead of waiting for that kij's psums to drain.
module ws_sequencer #(
  parameter int COL      = 8,
  parameter int LEN_KIJ  = 9,
  parameter int LEN_NIJ  = 36,
  parameter int LEN_ONIJ = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        l0_ready,
  input  logic        ofifo_valid,
  output logic [39:0] inst,
  output logic        busy,
  output logic        done
);
  // state      | meaning
  // IDLE       | waiting for start
  // WLOAD      | reading COL weight rows for the current kij
  // EXEC       | streaming LEN_NIJ activations for the current kij
  // GAP        | mode-switch bubble between kij passes
  // WAIT_DRAIN | all kij issued, waiting for the last psums to land in pmem
  // ACC        | 9 tap reads + 1 flush per output pixel
  // FIN        | done pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WLOAD = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_ACC   = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam int DRAIN_TOTAL = LEN_KIJ * LEN_NIJ;
  localparam int KW = $clog2(LEN_KIJ);
  localparam int CW = $clog2((LEN_NIJ > COL) ? LEN_NIJ : COL);
  localparam int DW = $clog2(DRAIN_TOTAL + 1);
  localparam int OW = $clog2(LEN_ONIJ);
  localparam logic [39:0] INST_IDLE = 40'h30_0403_0000;

  logic [2:0]    state, state_nx;
  logic [KW-1:0] kij, kij_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [DW-1:0] dcnt;
  logic [OW-1:0] onij, onij_nx;
  logic [3:0]    k, k_nx;
  logic [2:0]    ld_p, ex_p, md_p;
  logic          acc_d;
  logic          rd_ld, rd_ex, gap, pm_rd, acc_slot, drain, gap_go;
  logic [7:0]    a0_nx;
  logic [8:0]    pm_addr;
  logic [39:0]   inst_nx;

  assign drain = ofifo_valid && (dcnt < DW'(DRAIN_TOTAL));
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_FIN);

`ifdef WS_SEQ_OVERLAP_EN
  assign gap_go = 1'b1;
`else
  localparam logic [31:0] NIJ_U = 32'(LEN_NIJ);
  assign gap_go = (32'(dcnt) >= (32'(kij) + 32'd1) * NIJ_U);
`endif

  always_comb begin
    state_nx = state;
    kij_nx   = kij;
    cnt_nx   = cnt;
    onij_nx  = onij;
    k_nx     = k;
    rd_ld    = 1'b0;
    rd_ex    = 1'b0;
    gap      = 1'b0;
    pm_rd    = 1'b0;
    acc_slot = 1'b0;
    a0_nx    = 8'h00;
    pm_addr  = 9'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_WLOAD;
          kij_nx   = '0;
          cnt_nx   = '0;
        end
      end
      S_WLOAD: begin
        if (l0_ready) begin
          rd_ld = 1'b1;
          a0_nx = 8'h80 + 8'(kij) * 8'd8 + 8'(cnt);
          if (cnt == CW'(COL - 1)) begin
            cnt_nx   = '0;
            state_nx = S_EXEC;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (l0_ready) begin
          rd_ex = 1'b1;
          a0_nx = 8'(cnt);
          if (cnt == CW'(LEN_NIJ - 1)) begin
            cnt_nx   = '0;
            state_nx = S_GAP;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      S_GAP: begin
        gap = 1'b1;
        if (kij == KW'(LEN_KIJ - 1)) begin
          state_nx = S_WAIT;
        end else if (gap_go) begin
          kij_nx   = kij + 1'b1;
          state_nx = S_WLOAD;
        end
      end
      S_WAIT: begin
        if (dcnt == DW'(DRAIN_TOTAL)) begin
          state_nx = S_ACC;
          onij_nx  = '0;
          k_nx     = 4'd0;
        end
      end
      S_ACC: begin
        if (k == 4'd9) begin
          k_nx = 4'd0;
          if (onij == OW'(LEN_ONIJ - 1)) state_nx = S_FIN;
          else onij_nx = onij + 1'b1;
        end else begin
          pm_rd    = 1'b1;
          acc_slot = (k != 4'd0);
          // tap k of a 3x3 window anchored at output pixel onij in a 6-wide input image
          pm_addr  = 9'(k) * 9'(LEN_NIJ) + 9'(onij >> 2) * 9'd6 + 9'(onij & OW'(3))
                   + 9'(k / 4'd3) * 9'd6 + 9'(k % 4'd3);
          k_nx     = k + 1'b1;
        end
      end
      S_FIN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    inst_nx        = '0;
    inst_nx[39]    = (state == S_WLOAD) || (state == S_EXEC) || (state == S_GAP) || (state == S_WAIT);
    inst_nx[38]    = acc_d;
    inst_nx[37]    = !(drain || pm_rd);
    inst_nx[36]    = !drain;
    inst_nx[35:27] = drain ? 9'(dcnt) : pm_addr;
    inst_nx[26]    = 1'b1;
    inst_nx[17]    = !(rd_ld || rd_ex);
    inst_nx[16]    = 1'b1;
    inst_nx[15:8]  = a0_nx;
    inst_nx[7]     = drain;
    inst_nx[4]     = ld_p[1] | ex_p[1];
    inst_nx[3]     = ld_p[0] | ex_p[0];
    inst_nx[2]     = md_p[2];
    inst_nx[1]     = ex_p[2];
    inst_nx[0]     = ld_p[2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      kij   <= '0;
      cnt   <= '0;
      dcnt  <= '0;
      onij  <= '0;
      k     <= 4'd0;
      ld_p  <= 3'b000;
      ex_p  <= 3'b000;
      md_p  <= 3'b000;
      acc_d <= 1'b0;
      inst  <= INST_IDLE;
    end else begin
      state <= state_nx;
      kij   <= kij_nx;
      cnt   <= cnt_nx;
      onij  <= onij_nx;
      k     <= k_nx;
      ld_p  <= {ld_p[1:0], rd_ld};
      ex_p  <= {ex_p[1:0], rd_ex};
      md_p  <= {md_p[1:0], gap};
      acc_d <= acc_slot;
      inst  <= inst_nx;
      if (state == S_IDLE && start) dcnt <= '0;
      else if (drain) dcnt <= dcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_ws_sequencer.sv
// Scoreboard bench for ws_sequencer: stimulus pushes expected xmem/pmem addresses, a negedge monitor pops and checks.
module tb_ws_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, l0_ready, ofifo_valid;
  logic [39:0] inst;
  logic        busy, done;

  ws_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .l0_ready(l0_ready),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [39:0] INST_IDLE = 40'h30_0403_0000;

  int tests = 0;
  int fails = 0;
  logic [7:0] q_a0[$];
  logic [8:0] q_pw[$];
  logic [8:0] q_pr[$];
  logic [8:0] pr_log[$];
  int rd_cnt, ld_cnt, ex_cnt, mode_cnt, done_cnt, pr_seen, prev_k;
  logic hw [3];
  logic he [3];
  logic prev_pr, m_rd, m_w, m_e, m_pr;
  int exp5 [9] = '{7, 44, 81, 121, 158, 195, 235, 272, 309};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", name);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin hw[i] = 1'b0; he[i] = 1'b0; end
      prev_pr = 1'b0;
      prev_k  = 0;
    end else begin
      m_rd = !inst[17];
      m_w  = m_rd && (inst[15:8] >= 8'h80);
      m_e  = m_rd && (inst[15:8] < 8'h80);
      if (m_rd) begin
        rd_cnt++;
        chk("bypass_xmem_rd", 64'(inst[39]), 64'd1);
        if (q_a0.size() == 0) miss("a0_unexpected");
        else chk("a0_addr", 64'(inst[15:8]), 64'(q_a0.pop_front()));
      end
      chk("load_lat3", 64'(inst[0]), 64'(hw[2]));
      chk("exec_lat3", 64'(inst[1]), 64'(he[2]));
      chk("l0_wr_lat1", 64'(inst[3]), 64'(hw[0] | he[0]));
      chk("l0_rd_lat2", 64'(inst[4]), 64'(hw[1] | he[1]));
      hw[2] = hw[1]; hw[1] = hw[0]; hw[0] = m_w;
      he[2] = he[1]; he[1] = he[0]; he[0] = m_e;
      ld_cnt   += int'(inst[0]);
      ex_cnt   += int'(inst[1]);
      mode_cnt += int'(inst[2]);
      chk("acc_bit", 64'(inst[38]), 64'(prev_pr && prev_k != 0));
      if (inst[7]) begin
        chk("pmem_wr_cen_wen", 64'(inst[37:36]), 64'd0);
        if (q_pw.size() == 0) miss("pw_unexpected");
        else chk("pmem_wr_addr", 64'(inst[35:27]), 64'(q_pw.pop_front()));
      end
      m_pr = !inst[37] && inst[36];
      if (m_pr) begin
        chk("bypass_acc", 64'(inst[39]), 64'd0);
        chk("drain_before_acc", 64'(q_pw.size()), 64'd0);
        if (q_pr.size() == 0) miss("pr_unexpected");
        else chk("pmem_rd_addr", 64'(inst[35:27]), 64'(q_pr.pop_front()));
        pr_log.push_back(inst[35:27]);
        prev_k = pr_seen % 9;
        pr_seen++;
      end
      prev_pr = m_pr;
      chk("idle_fields", 64'({inst[26], inst[25:18], inst[6:5]}), 64'({1'b1, 8'h00, 2'b00}));
      if (done) done_cnt++;
    end
  end

  task automatic push_a0(int k0, int k1);
    for (int kk = k0; kk <= k1; kk++) begin
      for (int r = 0; r < 8; r++) q_a0.push_back(8'(128 + kk * 8 + r));
      for (int n = 0; n < 36; n++) q_a0.push_back(8'(n));
    end
  endtask

  task automatic push_pmem();
    for (int i = 0; i < 324; i++) q_pw.push_back(9'(i));
    for (int o = 0; o < 16; o++)
      for (int kk = 0; kk < 9; kk++)
        q_pr.push_back(9'(kk * 36 + (o / 4) * 6 + o % 4 + 6 * (kk / 3) + kk % 3));
  endtask

  task automatic clear_sb();
    @(posedge clk); #1;
    q_a0.delete(); q_pw.delete(); q_pr.delete(); pr_log.delete();
    rd_cnt = 0; ld_cnt = 0; ex_cnt = 0; mode_cnt = 0; done_cnt = 0; pr_seen = 0;
  endtask

  // start pulse plus first-read / first-load latency checks (l0_ready held high)
  task automatic start_checked(string name, logic valid);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; ofifo_valid = valid;
    chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
    chk({name, "_inst_idle_at_start"}, 64'(inst), 64'(INST_IDLE));
    @(negedge clk);
    chk({name, "_first_rd_cen0"}, 64'(inst[17]), 64'd0);
    chk({name, "_first_a0"}, 64'(inst[15:8]), 64'h80);
    chk({name, "_no_load_yet"}, 64'(inst[0]), 64'd0);
    repeat (3) @(negedge clk);
    chk({name, "_first_load"}, 64'(inst[0]), 64'd1);
  endtask

  task automatic wait_done(string name, bit toggle);
    int n = 0;
    while (!done && n < 3000) begin
      if (toggle) l0_ready = ~l0_ready;
      @(negedge clk);
      n++;
    end
    l0_ready = 1'b1;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
    end else begin
      @(negedge clk);
      chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
      chk({name, "_busy_after_done"}, 64'(busy), 64'd0);
      chk({name, "_inst_idle_after_done"}, 64'(inst), 64'(INST_IDLE));
    end
    ofifo_valid = 1'b0;
  endtask

  task automatic end_checks(string name, int exp_mode);
    chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({name, "_a0_left"}, 64'(q_a0.size()), 64'd0);
    chk({name, "_pw_left"}, 64'(q_pw.size()), 64'd0);
    chk({name, "_pr_left"}, 64'(q_pr.size()), 64'd0);
    chk({name, "_xmem_rds"}, 64'(rd_cnt), 64'd396);
    chk({name, "_loads"}, 64'(ld_cnt), 64'd72);
    chk({name, "_executes"}, 64'(ex_cnt), 64'd324);
    if (exp_mode >= 0) chk({name, "_mode_cycles"}, 64'(mode_cnt), 64'(exp_mode));
  endtask

  initial begin
    int n;
    int saved;
    reset = 1'b1; start = 1'b0; l0_ready = 1'b1; ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_inst", 64'(inst), 64'(INST_IDLE));
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_inst", 64'(inst), 64'(INST_IDLE));

    // pass 1: l0_ready held, ofifo_valid held from start
    clear_sb(); push_a0(0, 8); push_pmem();
    start_checked("p1", 1'b1);
    wait_done("p1", 1'b0);
    end_checks("p1", 9);
    if (pr_log.size() >= 54) begin
      for (int i = 0; i < 9; i++) chk("onij5_rd_addr", 64'(pr_log[45 + i]), 64'(exp5[i]));
    end else begin
      chk("onij5_rd_count", 64'(pr_log.size()), 64'd144);
    end

    // pass 2: l0_ready toggling every cycle
    clear_sb(); push_a0(0, 8); push_pmem();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; ofifo_valid = 1'b1;
    wait_done("p2", 1'b1);
    end_checks("p2", 9);

    // pass 3: reset during ACC onij 3, then a clean restart
    clear_sb(); push_a0(0, 8); push_pmem();
    start_checked("p3a", 1'b1);
    n = 0;
    while (pr_seen < 30 && n < 2000) begin @(posedge clk); #1; n++; end
    chk("p3_reached_acc_onij3", 64'(pr_seen >= 30), 64'd1);
    saved = done_cnt;
    reset = 1'b1; ofifo_valid = 1'b0;
    #1;
    chk("p3_busy_on_reset", 64'(busy), 64'd0);
    chk("p3_done_on_reset", 64'(done), 64'd0);
    chk("p3_inst_on_reset", 64'(inst), 64'(INST_IDLE));
    repeat (2) @(negedge clk);
    chk("p3_no_done_pulse", 64'(done_cnt), 64'(saved));
    clear_sb();
    reset = 1'b0;
    push_a0(0, 8); push_pmem();
    start_checked("p3b", 1'b1);
    wait_done("p3b", 1'b0);
    end_checks("p3b", 9);

    // pass 4: start while busy ignored; drain-gated GAP stalls with no OFIFO data
    clear_sb();
`ifdef WS_SEQ_OVERLAP_EN
    push_a0(0, 8);
`else
    push_a0(0, 0);
`endif
    start_checked("p4", 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (500) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("p4_busy_stalled", 64'(busy), 64'd1);
    chk("p4_no_done", 64'(done_cnt), 64'd0);
    chk("p4_a0_left", 64'(q_a0.size()), 64'd0);
`ifdef WS_SEQ_OVERLAP_EN
    chk("p4_rds_at_stall", 64'(rd_cnt), 64'd396);
`else
    chk("p4_rds_at_stall", 64'(rd_cnt), 64'd44);
    push_a0(1, 8);
`endif
    push_pmem();
    ofifo_valid = 1'b1;
    wait_done("p4", 1'b0);
    end_checks("p4", -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog");
  end
endmodule
